// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types and constants for the instruction cache
package icache_pkg;

    localparam int ICACHE_IDX_BITS = 7;
    localparam logic [31:0] ZERO32 = 32'h0000_0000;

    typedef enum logic {
        IC_IDLE = 1'b0,
        IC_FILL = 1'b1
    } ic_state_t;

    // Saturating increment for the optional statistics counters
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// rtl/icache_line_store.sv - valid/tag/data arrays, combinational read, synchronous write
module icache_line_store
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_IDX_BITS,
    parameter int TAG_BITS   = 30 - INDEX_BITS
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [31:0]           rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [31:0]           wr_data
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]  valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [31:0]         data_q [LINES];

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

    // Valid bits are the only reset state; tag/data are meaningless until valid
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data payload written on fill
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped word-line I-cache in front of memCtrl; optional ICACHE_STATS_EN
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_IDX_BITS
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        IF_in,
    input  logic [31:0] IF_pc_in,
    input  logic        flush_in,
    output logic        IF_instE_out,
    output logic [31:0] IF_inst_out,
    output logic        memCtrl_req_out,
    output logic [31:0] memCtrl_addr_out,
    input  logic        memCtrl_busy_in,
    input  logic        memCtrl_instE_in,
    input  logic [31:0] memCtrl_inst_in
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt_out,
    output logic [31:0] miss_cnt_out
`endif
);

    localparam int TAG_BITS = 30 - INDEX_BITS;

    ic_state_t   state_q, state_d;
    logic        drop_q, drop_d;
    logic [31:0] addr_q, addr_d;
    logic        inst_e_q, inst_e_d;
    logic [31:0] inst_q, inst_d;
    logic        wr_en_c;
    logic        hit_c;
    logic        miss_c;

    logic [INDEX_BITS-1:0] pc_idx;
    logic [TAG_BITS-1:0]   pc_tag;
    logic [INDEX_BITS-1:0] fill_idx;
    logic [TAG_BITS-1:0]   fill_tag;
    logic                  rd_valid;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [31:0]           rd_data;

    logic unused_ok;
    assign unused_ok = &{1'b0, memCtrl_busy_in, IF_pc_in[1:0]};

    assign pc_idx   = IF_pc_in[INDEX_BITS+1:2];
    assign pc_tag   = IF_pc_in[31:INDEX_BITS+2];
    assign fill_idx = addr_q[INDEX_BITS+1:2];
    assign fill_tag = addr_q[31:INDEX_BITS+2];

    icache_line_store #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_store (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rd_idx   (pc_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en_c && rdy_in),
        .wr_idx   (fill_idx),
        .wr_tag   (fill_tag),
        .wr_data  (memCtrl_inst_in)
    );

    // Request is dropped in the instE cycle so memCtrl does not start a second read
    assign memCtrl_req_out  = (state_q == IC_FILL) && !memCtrl_instE_in;
    assign memCtrl_addr_out = addr_q;
    assign IF_instE_out     = inst_e_q;
    assign IF_inst_out      = inst_q;

    // Next-state, fill control and response selection
    always_comb begin
        state_d  = state_q;
        drop_d   = drop_q;
        addr_d   = addr_q;
        inst_e_d = 1'b0;
        inst_d   = inst_q;
        wr_en_c  = 1'b0;
        hit_c    = 1'b0;
        miss_c   = 1'b0;
        case (state_q)
            IC_IDLE: begin
                if (IF_in && !flush_in) begin
                    if (rd_valid && (rd_tag == pc_tag)) begin
                        hit_c    = 1'b1;
                        inst_e_d = 1'b1;
                        inst_d   = rd_data;
                    end else begin
                        miss_c  = 1'b1;
                        addr_d  = {IF_pc_in[31:2], 2'b00};
                        state_d = IC_FILL;
                    end
                end
            end
            IC_FILL: begin
                if (memCtrl_instE_in) begin
                    wr_en_c = 1'b1;
                    state_d = IC_IDLE;
                    drop_d  = 1'b0;
                    if (!drop_q && !flush_in) begin
                        inst_e_d = 1'b1;
                        inst_d   = memCtrl_inst_in;
                    end
                end else if (flush_in) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = IC_IDLE;
        endcase
    end

    // State and output registers; rdy_in=0 freezes everything
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q  <= IC_IDLE;
            drop_q   <= 1'b0;
            addr_q   <= ZERO32;
            inst_e_q <= 1'b0;
            inst_q   <= ZERO32;
        end else if (rdy_in) begin
            state_q  <= state_d;
            drop_q   <= drop_d;
            addr_q   <= addr_d;
            inst_e_q <= inst_e_d;
            inst_q   <= inst_d;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;
    assign hit_cnt_out  = hit_cnt_q;
    assign miss_cnt_out = miss_cnt_q;

    // Saturating hit/miss counters
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            hit_cnt_q  <= ZERO32;
            miss_cnt_q <= ZERO32;
        end else if (rdy_in) begin
            if (hit_c)  hit_cnt_q  <= sat_inc32(hit_cnt_q);
            if (miss_c) miss_cnt_q <= sat_inc32(miss_cnt_q);
        end
    end
`else
    logic unused_stats;
    assign unused_stats = &{1'b0, hit_c, miss_c};
`endif

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - directed self-checking bench for icache
module tb_icache;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        IF_in;
    logic [31:0] IF_pc_in;
    logic        flush_in;
    logic        IF_instE_out;
    logic [31:0] IF_inst_out;
    logic        memCtrl_req_out;
    logic [31:0] memCtrl_addr_out;
    logic        memCtrl_busy_in;
    logic        memCtrl_instE_in;
    logic [31:0] memCtrl_inst_in;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_out;
    logic [31:0] miss_cnt_out;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    icache dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .rdy_in           (rdy_in),
        .IF_in            (IF_in),
        .IF_pc_in         (IF_pc_in),
        .flush_in         (flush_in),
        .IF_instE_out     (IF_instE_out),
        .IF_inst_out      (IF_inst_out),
        .memCtrl_req_out  (memCtrl_req_out),
        .memCtrl_addr_out (memCtrl_addr_out),
        .memCtrl_busy_in  (memCtrl_busy_in),
        .memCtrl_instE_in (memCtrl_instE_in),
        .memCtrl_inst_in  (memCtrl_inst_in)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt_out      (hit_cnt_out),
        .miss_cnt_out     (miss_cnt_out)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Issue a miss at pc, wait `lat` cycles with req held, then return data
    task automatic miss_fill(input string tag, input logic [31:0] pc, input int lat,
                             input logic [31:0] data, input logic expect_resp);
        IF_in    = 1'b1;
        IF_pc_in = pc;
        step();
        check({tag, "_req"}, {31'd0, memCtrl_req_out}, 32'd1);
        check({tag, "_addr"}, memCtrl_addr_out, {pc[31:2], 2'b00});
        for (int i = 1; i < lat; i++) begin
            step();
            check({tag, "_req_hold"}, {31'd0, memCtrl_req_out}, 32'd1);
        end
        memCtrl_instE_in = 1'b1;
        memCtrl_inst_in  = data;
        memCtrl_busy_in  = 1'b0;
        #1;
        check({tag, "_req_drop"}, {31'd0, memCtrl_req_out}, 32'd0);
        step();
        memCtrl_instE_in = 1'b0;
        memCtrl_inst_in  = 32'hDEAD_BEEF;
        IF_in            = 1'b0;
        flush_in         = 1'b0;
        #1;
        check({tag, "_inst_e"}, {31'd0, IF_instE_out}, {31'd0, expect_resp});
        if (expect_resp) check({tag, "_inst"}, IF_inst_out, data);
        step();
        check({tag, "_pulse_end"}, {31'd0, IF_instE_out}, 32'd0);
    endtask

    // Expect a one-cycle hit with no memory request
    task automatic hit(input string tag, input logic [31:0] pc, input logic [31:0] data);
        IF_in    = 1'b1;
        IF_pc_in = pc;
        step();
        IF_in = 1'b0;
        check({tag, "_inst_e"}, {31'd0, IF_instE_out}, 32'd1);
        check({tag, "_inst"}, IF_inst_out, data);
        check({tag, "_noreq"}, {31'd0, memCtrl_req_out}, 32'd0);
        step();
        check({tag, "_pulse_end"}, {31'd0, IF_instE_out}, 32'd0);
    endtask

    initial begin
        rst_in           = 1'b0;
        rdy_in           = 1'b1;
        IF_in            = 1'b1;
        IF_pc_in         = 32'h0000_0004;
        flush_in         = 1'b0;
        memCtrl_busy_in  = 1'b0;
        memCtrl_instE_in = 1'b0;
        memCtrl_inst_in  = 32'h0;

        // 1. reset with IF_in asserted
        step();
        step();
        check("rst_inst_e", {31'd0, IF_instE_out}, 32'd0);
        check("rst_req", {31'd0, memCtrl_req_out}, 32'd0);
        check("rst_inst", IF_inst_out, 32'd0);
        check("rst_addr", memCtrl_addr_out, 32'd0);
        IF_in  = 1'b0;
        rst_in = 1'b1;
        step();

        // 2. cold miss, 6-cycle memory latency
        memCtrl_busy_in = 1'b1;
        miss_fill("cold", 32'h0000_0004, 6, 32'h0050_0093, 1'b1);

        // 3. repeat fetch hits
        hit("rehit", 32'h0000_0004, 32'h0050_0093);
`ifdef ICACHE_STATS_EN
        check("stats_hit1", hit_cnt_out, 32'd1);
        check("stats_miss1", miss_cnt_out, 32'd1);
`endif

        // 4. conflict on index 1 evicts pc=0x4
        miss_fill("conf", 32'h0000_0204, 3, 32'h1111_1111, 1'b1);
        miss_fill("evict", 32'h0000_0004, 2, 32'h0050_0093, 1'b1);
        hit("conf_hit", 32'h0000_0004, 32'h0050_0093);
`ifdef ICACHE_STATS_EN
        check("stats_miss3", miss_cnt_out, 32'd3);
`endif

        // 5. flush mid-fill: response dropped, line still filled
        IF_in    = 1'b1;
        IF_pc_in = 32'h0000_0008;
        step();
        check("fl_req", {31'd0, memCtrl_req_out}, 32'd1);
        flush_in = 1'b1;
        IF_in    = 1'b0;
        step();
        flush_in = 1'b0;
        check("fl_still_req", {31'd0, memCtrl_req_out}, 32'd1);
        check("fl_addr", memCtrl_addr_out, 32'h0000_0008);
        step();
        memCtrl_instE_in = 1'b1;
        memCtrl_inst_in  = 32'h2222_2222;
        step();
        memCtrl_instE_in = 1'b0;
        check("fl_no_resp", {31'd0, IF_instE_out}, 32'd0);
        step();
        hit("fl_hit", 32'h0000_0008, 32'h2222_2222);

        // flush on the completion edge
        flush_in = 1'b0;
        IF_in    = 1'b1;
        IF_pc_in = 32'h0000_0010;
        step();
        IF_in = 1'b0;
        step();
        flush_in = 1'b1;
        miss_fill("flc", 32'h0000_0010, 1, 32'h4444_4444, 1'b0);
        hit("flc_hit", 32'h0000_0010, 32'h4444_4444);

        // 6. rdy_in low mid-fill freezes state
        IF_in    = 1'b1;
        IF_pc_in = 32'h0000_000C;
        step();
        IF_in    = 1'b0;
        IF_pc_in = 32'h0000_0F00;
        rdy_in   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rdy_req", {31'd0, memCtrl_req_out}, 32'd1);
            check("rdy_addr", memCtrl_addr_out, 32'h0000_000C);
            check("rdy_no_resp", {31'd0, IF_instE_out}, 32'd0);
        end
        rdy_in = 1'b1;
        memCtrl_instE_in = 1'b1;
        memCtrl_inst_in  = 32'h3333_3333;
        step();
        memCtrl_instE_in = 1'b0;
        check("rdy_resp", {31'd0, IF_instE_out}, 32'd1);
        check("rdy_inst", IF_inst_out, 32'h3333_3333);
        step();

        // a hit presented while rdy_in=0 must not respond
        rdy_in   = 1'b0;
        IF_in    = 1'b1;
        IF_pc_in = 32'h0000_000C;
        step();
        check("rdy_hit_frozen", {31'd0, IF_instE_out}, 32'd0);
        rdy_in = 1'b1;
        step();
        IF_in = 1'b0;
        check("rdy_hit_resume", IF_inst_out, 32'h3333_3333);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
